// File: rtl/eth_arb_pkg.sv
// Shared types and helpers for the Ethernet TX arbiter.
// Reused by the picker and any future RX demux/arbiter.
package eth_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    FLUSH,
    GAP
  } arb_state_t;

  localparam logic RR    = 1'b1;
  localparam logic FIXED = 1'b0;

  function automatic int bcnt_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/eth_rr_picker.sv
// Combinational request picker: round-robin from ptr, or lowest index.
// Rotates the request vector so the search start sits at bit 0.
module eth_rr_picker
  import eth_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          mode,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] base;
  logic [IW-1:0] off;
  logic [N-1:0]  rot;
  logic [IW:0]   sum;

  always_comb begin
    base = (mode == RR) ? ptr : '0;
    rot  = N'({req, req} >> base);
    off  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (IW+1)'(N)) idx = IW'(sum - (IW+1)'(N));
    else idx = sum[IW-1:0];
  end

  assign any = |req;

endmodule

// File: rtl/eth_tx_arbiter.sv
// N-channel frame-granular Ethernet TX arbiter with IFG insertion,
// runaway-frame abort/flush and per-channel frame counters.
module eth_tx_arbiter
  import eth_arb_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int IFG_CYCLES = 12,
  parameter int MAX_LEN    = 1518,
  parameter int RR_MODE    = 1,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         src_valid_i,
  input  logic [8*N_CH-1:0]       src_data_i,
  output logic [N_CH-1:0]         src_ack_o,
  output logic                    mac_tx_valid_o,
  output logic [7:0]              mac_tx_data_o,
  input  logic                    mac_tx_ack_i,
  output logic [$clog2(N_CH)-1:0] active_ch_o,
  output logic                    busy_o,
  output logic                    abort_o,
  output logic [CNT_W*N_CH-1:0]   frame_cnt_o
);

  localparam int IW = $clog2(N_CH);
  localparam int BW = bcnt_w(MAX_LEN);
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;
  localparam arb_state_t END_ST = (IFG_CYCLES > 0) ? GAP : IDLE;

  arb_state_t state;
  logic [IW-1:0] grant;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] next_ptr;
  logic [IW-1:0] pick_idx;
  logic pick_any;
  logic [BW-1:0] byte_cnt;
  logic [GW-1:0] gap_cnt;
  logic [N_CH-1:0][CNT_W-1:0] frame_cnt;
  logic sel_valid;
  logic [7:0] sel_data;
  logic at_max;

  eth_rr_picker #(.N(N_CH), .IW(IW)) u_picker (
    .req  (src_valid_i),
    .ptr  (rr_ptr),
    .mode ((RR_MODE != 0) ? RR : FIXED),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign sel_valid = src_valid_i[grant];
  assign sel_data  = src_data_i[{grant, 3'b000} +: 8];
  assign at_max    = (byte_cnt == BW'(MAX_LEN));
  assign next_ptr  = (grant == IW'(N_CH - 1)) ? '0 : grant + 1'b1;

  // Once MAX_LEN bytes went out, nothing more may reach the MAC.
  always_comb begin
    src_ack_o      = '0;
    mac_tx_valid_o = 1'b0;
    mac_tx_data_o  = '0;
    unique case (state)
      GRANT: begin
        mac_tx_valid_o   = sel_valid & ~at_max;
        mac_tx_data_o    = sel_data;
        src_ack_o[grant] = mac_tx_ack_i & ~at_max;
      end
      FLUSH: src_ack_o[grant] = sel_valid;
      default: ;
    endcase
  end

  assign busy_o      = (state == GRANT) || (state == FLUSH);
  assign abort_o     = (state == GRANT) && at_max && sel_valid;
  assign active_ch_o = grant;
  assign frame_cnt_o = frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      byte_cnt  <= '0;
      gap_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            grant    <= pick_idx;
            byte_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!sel_valid) begin
            frame_cnt[grant] <= frame_cnt[grant] + 1'b1;
            rr_ptr  <= next_ptr;
            gap_cnt <= GW'(IFG_CYCLES);
            state   <= END_ST;
          end else if (at_max) begin
            state <= FLUSH;
          end else if (mac_tx_ack_i) begin
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        FLUSH: begin
          if (!sel_valid) begin
            rr_ptr  <= next_ptr;
            gap_cnt <= GW'(IFG_CYCLES);
            state   <= END_ST;
          end
        end
        GAP: begin
          if (gap_cnt <= GW'(1)) state <= IDLE;
          else gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench: u_rr is RR/IFG=12/MAX_LEN=64, u_fx is fixed/IFG=0.
// Both use CNT_W=4 and three channels driven by a byte-source model.
module tb_eth_tx_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   sv [2];
  logic [8*N-1:0] sd [2];
  logic [N-1:0]   sa [2];
  logic           ma [2];
  logic           mv [2];
  logic [7:0]     md [2];
  logic [1:0]     ach [2];
  logic           bz [2];
  logic           ab [2];
  logic [4*N-1:0] fc [2];

  eth_tx_arbiter #(
    .N_CH(N), .IFG_CYCLES(12), .MAX_LEN(64), .RR_MODE(1), .CNT_W(4)
  ) u_rr (
    .clk(clk), .rst_n(rst_n),
    .src_valid_i(sv[0]), .src_data_i(sd[0]), .src_ack_o(sa[0]),
    .mac_tx_valid_o(mv[0]), .mac_tx_data_o(md[0]), .mac_tx_ack_i(ma[0]),
    .active_ch_o(ach[0]), .busy_o(bz[0]), .abort_o(ab[0]),
    .frame_cnt_o(fc[0])
  );

  eth_tx_arbiter #(
    .N_CH(N), .IFG_CYCLES(0), .MAX_LEN(64), .RR_MODE(0), .CNT_W(4)
  ) u_fx (
    .clk(clk), .rst_n(rst_n),
    .src_valid_i(sv[1]), .src_data_i(sd[1]), .src_ack_o(sa[1]),
    .mac_tx_valid_o(mv[1]), .mac_tx_data_o(md[1]), .mac_tx_ack_i(ma[1]),
    .active_ch_o(ach[1]), .busy_o(bz[1]), .abort_o(ab[1]),
    .frame_cnt_o(fc[1])
  );

  int checks, errors, cyc, L;
  int len [2][N];
  int pos [2][N];
  int frames [2][N];
  int flen [2][N];
  bit tog [2];
  logic [N-1:0] sa_s [2];
  logic mv_p [2];
  logic bz_p [2];
  int nrise [2], nfall [2], ng [2], nb [2], nab [2], ab_t [2], nflush [2];
  int rise_t [2][32];
  int fall_t [2][32];
  int glog [2][32];
  logic [7:0] strm [2][256];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      ma[i] = tog[i] ? cyc[0] : 1'b1;
      for (int k = 0; k < N; k++) begin
        sv[i][k] = (len[i][k] != 0);
        sd[i][8*k +: 8] = 8'((k << 6) | (pos[i][k] & 63));
      end
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < N; k++) begin
        len[i][k] = 0; pos[i][k] = 0; frames[i][k] = 0; flen[i][k] = 0;
      end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 2; i++) begin
      nrise[i] = 0; nfall[i] = 0; ng[i] = 0; nb[i] = 0;
      nab[i] = 0; ab_t[i] = 0; nflush[i] = 0;
    end
  endtask

  task automatic setup(input int i, input int k, input int nf, input int fl);
    frames[i][k] = nf;
    flen[i][k] = fl;
  endtask

  task automatic monitor(input int i);
    sa_s[i] = sa[i];
    if (!bz[i]) begin
      check("idle_ack", 32'(sa[i]), 0);
      check("idle_valid", 32'(mv[i]), 0);
      check("idle_data", 32'(md[i]), 0);
    end
    if (mv[i]) check("ack_pass", 32'(|sa[i]), 32'(ma[i]));
    if (mv[i] && ma[i]) begin
      if (nb[i] < 256) strm[i][nb[i]] = md[i];
      nb[i]++;
    end
    if (mv[i] && !mv_p[i]) begin
      if (nrise[i] < 32) rise_t[i][nrise[i]] = cyc;
      nrise[i]++;
    end
    if (!mv[i] && mv_p[i]) begin
      if (nfall[i] < 32) fall_t[i][nfall[i]] = cyc;
      nfall[i]++;
    end
    if (bz[i] && !bz_p[i]) begin
      if (ng[i] < 32) glog[i][ng[i]] = int'(ach[i]);
      ng[i]++;
    end
    if (ab[i]) begin
      ab_t[i] = cyc;
      nab[i]++;
    end
    if (bz[i] && !mv[i] && sa[i] != 0) nflush[i]++;
    mv_p[i] = mv[i];
    bz_p[i] = bz[i];
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) monitor(i);
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < N; k++) begin
        if (len[i][k] != 0) begin
          if (sa_s[i][k]) begin
            len[i][k]--;
            pos[i][k]++;
          end
        end else if (frames[i][k] != 0) begin
          len[i][k] = flen[i][k];
          pos[i][k] = 0;
          frames[i][k]--;
        end
      end
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int exp4 [4];
    int guard;
    checks = 0; errors = 0; cyc = 0; L = 0;
    for (int i = 0; i < 2; i++) begin
      tog[i] = 1'b0; sa_s[i] = '0; mv_p[i] = 1'b0; bz_p[i] = 1'b0;
    end
    clear_src();
    clear_mon();
    drive();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    check("rst_valid", 32'(mv[0]), 0);
    check("rst_data", 32'(md[0]), 0);
    check("rst_ack", 32'(sa[0]), 0);
    check("rst_busy", 32'(bz[0]), 0);
    check("rst_abort", 32'(ab[0]), 0);
    check("rst_ach", 32'(ach[0]), 0);
    check("rst_cnt_rr", 32'(fc[0]), 0);
    check("rst_cnt_fx", 32'(fc[1]), 0);

    // two 60-byte frames requested together, IFG=12
    clear_mon();
    setup(0, 0, 1, 60);
    setup(0, 1, 1, 60);
    tick();
    L = cyc;
    run(160);
    check("t2_lat", rise_t[0][0] - L, 1);
    check("t2_ifg", rise_t[0][1] - fall_t[0][0], 14);
    check("t2_bytes", nb[0], 120);
    check("t2_b0", strm[0][0], 8'h00);
    check("t2_b59", strm[0][59], 8'h3b);
    check("t2_b60", strm[0][60], 8'h40);
    check("t2_b119", strm[0][119], 8'h7b);
    check("t2_g0", glog[0][0], 0);
    check("t2_g1", glog[0][1], 1);
    check("t2_cnt", fc[0], 12'h011);

    // RR fairness on u_rr, fixed priority with IFG=0 on u_fx
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_mon();
    for (int k = 0; k < N; k++) setup(0, k, 3, 4);
    setup(1, 0, 2, 4);
    setup(1, 2, 2, 4);
    tick();
    L = cyc;
    run(200);
    for (int g = 0; g < 9; g++) check("t3_order", glog[0][g], g % 3);
    check("t3_frames", ng[0], 9);
    check("t3_cnt", fc[0], 12'h333);
    exp4 = '{0, 0, 2, 2};
    for (int g = 0; g < 4; g++) check("t4_order", glog[1][g], exp4[g]);
    check("t4_frames", ng[1], 4);
    check("t4_ifg0", rise_t[1][1] - fall_t[1][0], 2);
    check("t4_cnt", fc[1], 12'h202);

    // runaway frame on u_rr, gated MAC acks on u_fx
    clear_mon();
    setup(0, 1, 1, 100);
    tog[1] = 1'b1;
    setup(1, 1, 1, 5);
    tick();
    L = cyc;
    run(130);
    tog[1] = 1'b0;
    check("t5_abort_n", nab[0], 1);
    check("t5_abort_t", ab_t[0] - L, 65);
    check("t5_bytes", nb[0], 64);
    check("t5_flush_acks", nflush[0], 36);
    check("t5_drained", len[0][1], 0);
    check("t5_cnt", fc[0], 12'h333);
    check("t5_grant", glog[0][0], 1);
    check("t8_bytes", nb[1], 5);
    check("t8_drained", len[1][1], 0);
    check("t8_cnt", fc[1], 12'h212);

    // reset mid-frame at byte 20
    clear_mon();
    setup(0, 2, 1, 40);
    guard = 0;
    while (nb[0] < 20 && guard < 100) begin
      tick();
      guard++;
    end
    check("t6_reach20", nb[0], 20);
    rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(mv[0]), 0);
    check("t6_data", 32'(md[0]), 0);
    check("t6_ack", 32'(sa[0]), 0);
    check("t6_busy", 32'(bz[0]), 0);
    check("t6_ach", 32'(ach[0]), 0);
    check("t6_cnt", fc[0], 0);
    clear_src();
    drive();
    tick();
    rst_n = 1'b1;
    clear_mon();
    setup(0, 1, 1, 3);
    setup(0, 2, 1, 3);
    setup(1, 0, 17, 2);
    tick();
    L = cyc;
    run(90);
    check("t6_lat", rise_t[0][0] - L, 1);
    check("t6_ptr0", glog[0][0], 1);
    check("t6_next", glog[0][1], 2);
    check("t7_frames", ng[1], 17);
    check("t7_bytes", nb[1], 34);
    check("t7_wrap", fc[1], 12'h001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
